// File: rtl/uart_mmio.sv
// Memory-mapped UART: RX/TX byte FIFOs around a prescaled 8N1 core, sticky error flags, level irq.
// Registered reads (DO valid one edge after cs). `define UART_LOOPBACK_EN enables CTRL bit2 internal loopback.

module uart_mmio_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_dat,
    input  logic          pop,
    output logic [7:0]    pop_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = count[AW];
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO still lands when the same edge frees a slot.
    assign do_push = push & (~full | do_pop);
    assign pop_dat = empty ? 8'h00 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module uart_mmio_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] prescale,
    input  logic [7:0]  input_axis_tdata,
    input  logic        input_axis_tvalid,
    output logic        input_axis_tready,
    output logic [7:0]  output_axis_tdata,
    output logic        output_axis_tvalid,
    input  logic        output_axis_tready,
    input  logic        rxd,
    output logic        txd,
    output logic        tx_busy,
    output logic        rx_frame_error
);
    logic [18:0] period;
    logic [18:0] tx_cnt, rx_cnt;
    logic [8:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic [3:0]  tx_bit, rx_bit;
    logic        rx_busy, rxd_q;

    // One bit time is prescale*8 clocks.
    assign period            = {prescale, 3'b000};
    assign input_axis_tready = ~tx_busy;
    assign output_axis_tdata = rx_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_sr   <= '0;
            tx_bit  <= '0;
            tx_cnt  <= '0;
        end else if (!tx_busy) begin
            if (input_axis_tvalid) begin
                tx_busy <= 1'b1;
                txd     <= 1'b0;
                tx_sr   <= {1'b1, input_axis_tdata};
                tx_bit  <= 4'd9;
                tx_cnt  <= period - 19'd1;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 19'd1;
        end else if (tx_bit != '0) begin
            txd    <= tx_sr[0];
            tx_sr  <= {1'b1, tx_sr[8:1]};
            tx_bit <= tx_bit - 4'd1;
            tx_cnt <= period - 19'd1;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_q              <= 1'b1;
            rx_busy            <= 1'b0;
            rx_cnt             <= '0;
            rx_bit             <= '0;
            rx_sr              <= '0;
            output_axis_tvalid <= 1'b0;
            rx_frame_error     <= 1'b0;
        end else begin
            rxd_q          <= rxd;
            rx_frame_error <= 1'b0;
            if (output_axis_tvalid && output_axis_tready) output_axis_tvalid <= 1'b0;
            if (!rx_busy) begin
                if (!rxd_q) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= {1'b0, period[18:1]};
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 19'd1;
            end else begin
                rx_cnt <= period - 19'd1;
                rx_bit <= rx_bit + 4'd1;
                // Sampling mid-bit: a start bit that has gone high again was a glitch.
                if (rx_bit == 4'd0) begin
                    if (rxd_q) rx_busy <= 1'b0;
                end else if (rx_bit != 4'd9) begin
                    rx_sr <= {rxd_q, rx_sr[7:1]};
                end else begin
                    rx_busy <= 1'b0;
                    if (rxd_q) output_axis_tvalid <= 1'b1;
                    else       rx_frame_error     <= 1'b1;
                end
            end
        end
    end
endmodule

module uart_mmio #(
    parameter int          RX_DEPTH_LOG2  = 4,
    parameter int          TX_DEPTH_LOG2  = 4,
    parameter logic [15:0] PRESCALE_RESET = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Address,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       rxd,
    output logic       txd
);
`ifdef UART_LOOPBACK_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

    logic                   rd, wr, st_wr;
    logic [2:0]             ctrl;
    logic [15:0]            presc;
    logic                   rxovr, ferr, txovf;
    logic [7:0]             rdata, status;
    logic [7:0]             rx_dat, rx_head, tx_dat;
    logic                   rx_vld, rx_pop, rx_full, rx_empty;
    logic                   tx_vld, tx_rdy, tx_push, tx_pop, tx_full, tx_empty, tx_busy;
    logic                   frame_err, core_rxd, core_txd;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic [TX_DEPTH_LOG2:0] tx_count;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    assign rd      = cs & rw;
    assign wr      = cs & ~rw;
    assign st_wr   = wr & (Address == 4'h1);
    assign rx_pop  = rd & (Address == 4'h0);
    assign tx_push = wr & (Address == 4'h0);
    assign tx_vld  = ~tx_empty;
    assign tx_pop  = tx_vld & tx_rdy;

`ifdef UART_LOOPBACK_EN
    assign core_rxd = ctrl[2] ? core_txd : rxd;
    assign txd      = ctrl[2] ? 1'b1 : core_txd;
`else
    assign core_rxd = rxd;
    assign txd      = core_txd;
`endif

    uart_mmio_fifo #(.AW(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_vld), .push_dat(rx_dat), .pop(rx_pop),
        .pop_dat(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    uart_mmio_fifo #(.AW(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .push_dat(DI), .pop(tx_pop),
        .pop_dat(tx_dat), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    uart_mmio_core u_core (
        .clk(clk), .rst(rst), .prescale(presc),
        .input_axis_tdata(tx_dat), .input_axis_tvalid(tx_vld), .input_axis_tready(tx_rdy),
        .output_axis_tdata(rx_dat), .output_axis_tvalid(rx_vld), .output_axis_tready(1'b1),
        .rxd(core_rxd), .txd(core_txd), .tx_busy(tx_busy), .rx_frame_error(frame_err)
    );

    assign status = {irq, txovf, ferr, rxovr, rx_full, tx_empty & ~tx_busy, ~tx_full, ~rx_empty};

    always_comb begin
        rdata = 8'h00;
        case (Address)
            4'h0:    rdata = rx_head;
            4'h1:    rdata = status;
            4'h2:    rdata = {5'b0, ctrl};
            4'h3:    rdata = sat8(32'(rx_count));
            4'h4:    rdata = sat8(32'(tx_count));
            4'hA:    rdata = presc[15:8];
            4'hB:    rdata = presc[7:0];
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DO    <= 8'h00;
            ctrl  <= 3'b000;
            presc <= PRESCALE_RESET;
            rxovr <= 1'b0;
            ferr  <= 1'b0;
            txovf <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (rd) DO <= rdata;
            if (wr && Address == 4'h2) ctrl <= DI[2:0] & CTRL_MASK;
            if (wr && Address == 4'hA) presc[15:8] <= DI;
            if (wr && Address == 4'hB) presc[7:0]  <= DI;
            // Set terms are OR'd after the clear so a coincident event wins.
            rxovr <= (rxovr & ~(st_wr & DI[4])) | (rx_vld & rx_full & ~rx_pop);
            ferr  <= (ferr  & ~(st_wr & DI[5])) | frame_err;
            txovf <= (txovf & ~(st_wr & DI[6])) | (tx_push & tx_full & ~tx_pop);
            irq   <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty);
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: register access, FIFOs, flags, irq and serial framing at prescale 1.
module tb_uart_mmio;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Address;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw, cs;
    logic       irq;
    wire        rxd;
    logic       txd;
    logic       rxd_drv, loop_ext;
    int         total = 0;
    int         passed = 0;

    assign rxd = loop_ext ? txd : rxd_drv;

    uart_mmio dut (
        .clk(clk), .rst(rst), .Address(Address), .DI(DI), .DO(DO),
        .rw(rw), .cs(cs), .irq(irq), .rxd(rxd), .txd(txd)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; Address = a; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; Address = a;
        @(negedge clk);
        cs = 1'b0;
        d = DO;
    endtask

    // 8N1 frame at prescale 1 (8 clocks per bit); stop_bit=0 forces a framing error.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = bits[i];
            repeat (8) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1; cs = 1'b0; rw = 1'b1; Address = 4'h0; DI = 8'h00;
        rxd_drv = 1'b1; loop_ext = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (txd !== 1'b1) $display("FAIL reset_txd got %b expected 1", txd); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL reset_irq got %b expected 0", irq); else passed++;
        total++; if (DO !== 8'h00) $display("FAIL reset_do got %h expected 00", DO); else passed++;
        rst = 1'b0;
        bus_read(4'h1, d);
        total++; if (d !== 8'h06) $display("FAIL reset_status got %h expected 06", d); else passed++;
        bus_read(4'h2, d);
        total++; if (d !== 8'h00) $display("FAIL reset_ctrl got %h expected 00", d); else passed++;
        bus_read(4'hB, d);
        total++; if (d !== 8'h00) $display("FAIL reset_presc_lo got %h expected 00", d); else passed++;
        bus_read(4'h0, d);
        total++; if (d !== 8'h00) $display("FAIL empty_data got %h expected 00", d); else passed++;
        bus_read(4'h7, d);
        total++; if (d !== 8'h00) $display("FAIL unmapped got %h expected 00", d); else passed++;
    endtask

    task automatic test_tx_overflow();
        logic [7:0] d;
        bus_write(4'hA, 8'hFF);
        bus_write(4'hB, 8'hFF);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            cs = 1'b1; rw = 1'b0; Address = 4'h0; DI = 8'(i + 1);
        end
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
        bus_read(4'h4, d);
        total++; if (d !== 8'h10) $display("FAIL txovf_count got %h expected 10", d); else passed++;
        bus_read(4'h1, d);
        total++; if (d !== 8'h40) $display("FAIL txovf_status got %h expected 40", d); else passed++;
        total++; if (txd !== 1'b0) $display("FAIL txovf_start_bit got %b expected 0", txd); else passed++;
        bus_write(4'h1, 8'h40);
        bus_read(4'h1, d);
        total++; if (d !== 8'h00) $display("FAIL txovf_clear got %h expected 00", d); else passed++;
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (txd !== 1'b1) $display("FAIL midtx_txd got %b expected 1", txd); else passed++;
        @(negedge clk);
        rst = 1'b0;
        bus_read(4'h4, d);
        total++; if (d !== 8'h00) $display("FAIL midtx_count got %h expected 00", d); else passed++;
        bus_read(4'h1, d);
        total++; if (d !== 8'h06) $display("FAIL midtx_status got %h expected 06", d); else passed++;
        bus_read(4'hA, d);
        total++; if (d !== 8'h00) $display("FAIL midtx_presc_hi got %h expected 00", d); else passed++;
    endtask

    task automatic test_loopback();
        logic [7:0] d, exp_ctrl;
        bus_write(4'hA, 8'h00);
        bus_write(4'hB, 8'h01);
        bus_write(4'h2, 8'h04);
`ifdef UART_LOOPBACK_EN
        exp_ctrl = 8'h04;
`else
        exp_ctrl = 8'h00;
        loop_ext = 1'b1;
`endif
        bus_read(4'h2, d);
        total++; if (d !== exp_ctrl) $display("FAIL loop_ctrl got %h expected %h", d, exp_ctrl); else passed++;
        bus_write(4'h0, 8'h55);
        bus_write(4'h0, 8'hAA);
        for (int i = 0; i < 300; i++) begin
            bus_read(4'h3, d);
            if (d == 8'h02) break;
        end
        total++; if (d !== 8'h02) $display("FAIL loop_rx_count got %h expected 02", d); else passed++;
        bus_read(4'h0, d);
        total++; if (d !== 8'h55) $display("FAIL loop_byte0 got %h expected 55", d); else passed++;
        bus_read(4'h0, d);
        total++; if (d !== 8'hAA) $display("FAIL loop_byte1 got %h expected aa", d); else passed++;
        bus_read(4'h0, d);
        total++; if (d !== 8'h00) $display("FAIL loop_empty got %h expected 00", d); else passed++;
        bus_read(4'h1, d);
        total++; if (d !== 8'h06) $display("FAIL loop_status got %h expected 06", d); else passed++;
        bus_write(4'h2, 8'h00);
        loop_ext = 1'b0;
    endtask

    task automatic test_rx_overrun();
        logic [7:0] d;
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        bus_read(4'h3, d);
        total++; if (d !== 8'h10) $display("FAIL ovr_count got %h expected 10", d); else passed++;
        bus_read(4'h1, d);
        total++; if (d !== 8'h1F) $display("FAIL ovr_status got %h expected 1f", d); else passed++;
        for (int i = 1; i <= 16; i++) begin
            bus_read(4'h0, d);
            total++; if (d !== 8'(i)) $display("FAIL ovr_data_%0d got %h expected %h", i, d, 8'(i)); else passed++;
        end
        bus_read(4'h0, d);
        total++; if (d !== 8'h00) $display("FAIL ovr_drained got %h expected 00", d); else passed++;
        bus_write(4'h1, 8'h10);
        bus_read(4'h1, d);
        total++; if (d !== 8'h06) $display("FAIL ovr_clear got %h expected 06", d); else passed++;
    endtask

    task automatic test_frame_error();
        logic [7:0] d;
        send_frame(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        bus_read(4'h1, d);
        total++; if (d !== 8'h26) $display("FAIL ferr_status got %h expected 26", d); else passed++;
        bus_read(4'h3, d);
        total++; if (d !== 8'h00) $display("FAIL ferr_count got %h expected 00", d); else passed++;
        bus_write(4'h1, 8'h20);
        bus_read(4'h1, d);
        total++; if (d !== 8'h06) $display("FAIL ferr_clear got %h expected 06", d); else passed++;
    endtask

    task automatic test_irq();
        logic [7:0] d;
        logic       seen;
        bus_write(4'h2, 8'h01);
        @(negedge clk);
        total++; if (irq !== 1'b0) $display("FAIL irq_idle got %b expected 0", irq); else passed++;
        seen = 1'b0;
        fork
            send_frame(8'h77, 1'b1);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (dut.rx_vld) begin seen = 1'b1; break; end
                end
                @(negedge clk);
                total++; if (irq !== 1'b0) $display("FAIL irq_lag1 got %b expected 0", irq); else passed++;
                @(negedge clk);
                total++; if (irq !== 1'b1) $display("FAIL irq_lag2 got %b expected 1", irq); else passed++;
            end
        join
        total++; if (seen !== 1'b1) $display("FAIL irq_rx_timeout got %b expected 1", seen); else passed++;
        bus_read(4'h0, d);
        total++; if (d !== 8'h77) $display("FAIL irq_data got %h expected 77", d); else passed++;
        total++; if (irq !== 1'b1) $display("FAIL irq_pop_lag got %b expected 1", irq); else passed++;
        @(negedge clk);
        total++; if (irq !== 1'b0) $display("FAIL irq_pop_clear got %b expected 0", irq); else passed++;
        bus_write(4'h2, 8'h02);
        total++; if (irq !== 1'b0) $display("FAIL irq_txie_lag got %b expected 0", irq); else passed++;
        @(negedge clk);
        total++; if (irq !== 1'b1) $display("FAIL irq_txie got %b expected 1", irq); else passed++;
        bus_read(4'h1, d);
        total++; if (d !== 8'h86) $display("FAIL irq_status got %h expected 86", d); else passed++;
    endtask

    initial begin
        test_reset();
        test_tx_overflow();
        test_reset_mid_tx();
        test_loopback();
        test_rx_overrun();
        test_frame_error();
        test_irq();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Parametrised memory-mapped UART peripheral with independent RX and TX FIFOs, a programmable prescaler, sticky error flags and a level interrupt. It sits on the 8-bit CPU I/O bus (4-bit `Address`, `DI`/`DO`, `rw`, `cs`) beside the LED/switch I/O block and wraps the existing `uart` core through its AXI-stream ports. It adds the buffered TX path, RX buffering and interrupt generation that the current I/O block lacks.

## Interface
- `RX_DEPTH_LOG2`, 4: RX FIFO depth = 2^N bytes (N ≥ 1).
- `TX_DEPTH_LOG2`, 4: TX FIFO depth = 2^N bytes (N ≥ 1).
- `PRESCALE_RESET`, 16'h0000: prescaler value after reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `Address` in 4: register select.
- `DI` in 8: write data.
- `DO` out 8: registered read data.
- `rw` in 1: 1 = read, 0 = write.
- `cs` in 1: access strobe. Each cycle with `cs` high is one access.
- `irq` out 1: registered level interrupt.
- `rxd` in 1: serial input.
- `txd` out 1: serial output.

## Operation
- Register map:
  - 0x0 DATA: read pops RX FIFO, returning 8'h00 if empty. Write pushes TX FIFO; if full, the byte is dropped and TXOVF is set.
  - 0x1 STATUS, read: bit0 RX nonempty, bit1 TX not full, bit2 TX idle (FIFO empty and core not busy), bit3 RX full, bit4 RXOVR, bit5 FRAMEERR, bit6 TXOVF, bit7 `irq`. Write: 1 in bits 6:4 clears that flag; other bits are ignored.
  - 0x2 CTRL RW: bit0 RXIE, bit1 TXIE, bit2 LOOP (see Configuration). Other bits read 0.
  - 0x3 RX_COUNT: read-only FIFO level, saturating at 8'hFF.
  - 0x4 TX_COUNT: read-only FIFO level, saturating at 8'hFF.
  - 0xA PRESC_HI and 0xB PRESC_LO: RW bytes of the 16-bit prescale fed to the core.
  - All other addresses read 8'h00; writes to them are ignored.
- RX path:
  - `output_axis_tready` is tied to 1.
  - On `tvalid`, the byte is pushed if the RX FIFO is not full; otherwise it is dropped and RXOVR is set.
  - A `rx_frame_error` pulse sets FRAMEERR.
- TX path:
  - The FIFO head drives `input_axis_tdata`; `input_axis_tvalid` = TX FIFO not empty.
  - The FIFO pops on `tvalid & tready`.
- FIFOs:
  - Circular, with pointer width N and count width N+1.
  - Simultaneous push and pop when full: both take effect and the count is unchanged.
  - Simultaneous push and pop when empty: the pop returns 8'h00 and the push still lands, so the count becomes 1.
- Sticky-flag conflict: if a clear and a set event coincide, the set wins.
- `irq` = (RXIE & RX nonempty) | (TXIE & TX FIFO empty), registered.

## Timing
- Reset values:
  - `DO` = 0, CTRL = 0, prescaler = `PRESCALE_RESET`.
  - FIFOs empty, flags 0, `irq` = 0, `txd` = 1.
- Reset mid-frame aborts the frame; `txd` returns to 1 immediately.
- Read: `DO` is valid on the edge after the `cs` cycle. `DO` holds its value when there is no read access.
- Pop/push from the bus takes effect at the same edge as the access. STATUS and COUNT reads reflect state before that edge.
- RX byte: visible in RX_COUNT one cycle after `tvalid`.
- `irq` lags the FIFO/CTRL state change by one cycle.
- TX: a byte written to an empty FIFO with the core idle is presented to the core on the next cycle.

## Configuration
- `UART_LOOPBACK_EN`:
  - Defined: CTRL bit2 is implemented. When set, the core's `rxd` is driven from the core's `txd` and external `txd` is held at 1.
  - Undefined: bit2 reads 0, writes to it are ignored, and the core is wired straight to `rxd`/`txd`.

## Test plan
- Reset, then read STATUS and CTRL -> 8'h06 and 8'h00. `irq` = 0, `txd` = 1.
- Loopback (macro defined): prescaler 16'h0001, CTRL = 8'h04, write 0x55 then 0xAA, wait for both frames -> RX_COUNT = 2. DATA reads return 0x55, 0xAA, then 0x00.
- TX overflow: prescaler 16'hFFFF, write 2^TX_DEPTH_LOG2 + 2 bytes back-to-back -> TX_COUNT = 16 and STATUS bit6 = 1. Writing 8'h40 to STATUS clears bit6.
- RX overrun: drive 17 frames (0x01..0x11) on `rxd` with no reads -> RX_COUNT = 16 and bit4 = 1. Reads return 0x01..0x10 in order.
- IRQ: CTRL = 8'h01, receive one byte -> `irq` = 1 two cycles after `tvalid`. Reading DATA -> `irq` = 0 two cycles later. CTRL = 8'h02 with TX empty -> `irq` = 1.
- Assert `rst` mid-transmit -> `txd` = 1, TX_COUNT = 0, STATUS = 8'h06 after release.
